// File: rtl/csa_pkg.sv
// csa_pkg: shared FSM encoding and derived sizing helpers for csa_resolver.
package csa_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction
    function automatic int idx_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: CHUNK-bit ripple-carry adder used for one resolver slice.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] iA,
    input  logic [CHUNK-1:0] iB,
    input  logic             iCin,
    output logic [CHUNK-1:0] oS,
    output logic             oCout
);
    logic [CHUNK:0] w_c;
    assign w_c[0] = iCin;
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign oS[i]    = iA[i] ^ iB[i] ^ w_c[i];
        assign w_c[i+1] = (iA[i] & iB[i]) | (w_c[i] & (iA[i] ^ iB[i]));
    end
    assign oCout = w_c[CHUNK];
endmodule

// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save pair into binary, CHUNK bits per cycle,
// with valid/ready handshakes on both sides and no overlap between pairs.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iS,
    input  logic [WIDTH:0]   iC,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH+1:0] oSum
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_w(NCHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("csa_resolver: WIDTH must be a multiple of CHUNK");
    end

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH:0]   r_c;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [WIDTH+1:0] r_sum;
    logic [CHUNK-1:0] w_a, w_b, w_res;
    logic             w_cout, w_last;

    // One shared adder; the current slice is selected by shifting the captured operands.
    assign w_a    = CHUNK'(r_s >> (r_idx * CHUNK));
    assign w_b    = CHUNK'(r_c >> (r_idx * CHUNK));
    assign w_last = (r_idx == IW'(NCHUNK - 1));

    chunk_adder #(.CHUNK(CHUNK)) u_add (
        .iA    (w_a),
        .iB    (w_b),
        .iCin  (r_carry),
        .oS    (w_res),
        .oCout (w_cout)
    );

    always_comb begin
        w_next = (r_state == IDLE && iValid) ? RUN  :
                 (r_state == RUN  && w_last) ? DONE :
                 (r_state == DONE && iReady) ? IDLE :
                 (r_state == IDLE || r_state == RUN || r_state == DONE) ? r_state : IDLE;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_c     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && iValid) begin
                r_s     <= iS;
                r_c     <= iC;
                r_carry <= 1'b0;
                r_idx   <= '0;
            end
            if (r_state == RUN) begin
                r_sum[r_idx*CHUNK +: CHUNK] <= w_res;
                r_carry                     <= w_cout;
                r_idx                       <= r_idx + 1'b1;
                // Top two bits: carry MSB plus the final ripple carry; cannot overflow.
                if (w_last)
                    r_sum[WIDTH+1:WIDTH] <= {1'b0, r_c[WIDTH]} + {1'b0, w_cout};
            end
        end
    end

    assign oReady = (r_state == IDLE);
    assign oValid = (r_state == DONE);
    assign oSum   = r_sum;
endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: directed and randomized checks of csa_resolver (8/4 and 16/16)
// against plain-arithmetic expected sums kept in in-order scoreboards.
module tb_csa_resolver;
    logic        clk = 1'b0;
    logic        rst;
    logic        v8, r8, ov8, ir8;
    logic [7:0]  s8;
    logic [8:0]  c8;
    logic [9:0]  sum8, e8;
    logic        v16, r16, ov16, ir16;
    logic [15:0] s16;
    logic [16:0] c16;
    logic [17:0] sum16, e16;

    int n_chk = 0, n_fail = 0;
    logic mon = 1'b0;
    int cyc = 0, acc8 = 0, acc16 = 0, res8 = 0, res16 = 0;
    logic pv8 = 1'b0, pv16 = 1'b0;
    logic [9:0]  q8[$];
    logic [17:0] q16[$];
    int t8[$], t16[$];

    always #5 clk = ~clk;

    csa_resolver #(.WIDTH(8), .CHUNK(4)) u_dut8 (
        .iClk(clk), .iRst(rst), .iValid(v8), .oReady(r8), .iS(s8), .iC(c8),
        .oValid(ov8), .iReady(ir8), .oSum(sum8)
    );

    csa_resolver #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .iClk(clk), .iRst(rst), .iValid(v16), .oReady(r16), .iS(s16), .iC(c16),
        .oValid(ov16), .iReady(ir16), .oSum(sum16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one pair to the 8/4 instance, hold it in DONE for `stall` cycles, then drain.
    task automatic run8(input logic [7:0] s, input logic [8:0] c, input int stall);
        logic [9:0] want;
        int n;
        want = 10'(s) + 10'(c);
        chk("rdy_idle", 32'(r8), 1);
        v8 = 1'b1; s8 = s; c8 = c; ir8 = 1'b0;
        step();
        v8 = 1'b0;
        n = 0;
        while (!ov8 && n < 20) begin
            step();
            n++;
        end
        chk("lat8", n, 2);
        chk("sum8", 32'(sum8), 32'(want));
        chk("rdy_done", 32'(r8), 0);
        for (int i = 0; i < stall; i++) begin
            if (i == 1) begin
                v8 = 1'b1; s8 = 8'h55; c8 = 9'h0;
            end
            step();
            v8 = 1'b0;
            chk("stall_sum", 32'(sum8), 32'(want));
            chk("stall_ov", 32'(ov8), 1);
            chk("stall_rdy", 32'(r8), 0);
        end
        ir8 = 1'b1;
        step();
        ir8 = 1'b0;
        chk("ov_drop", 32'(ov8), 0);
        chk("rdy_back", 32'(r8), 1);
        if (stall > 0) begin
            repeat (4) step();
            chk("no_latch", 32'(ov8), 0);
            chk("hold_sum", 32'(sum8), 32'(want));
        end
    endtask

    // Negedge monitor: handshakes seen here are the ones the next rising edge takes.
    always @(negedge clk) begin
        if (mon) begin
            cyc++;
            if (v8 && r8) begin q8.push_back(e8); t8.push_back(cyc); acc8++; end
            if (v16 && r16) begin q16.push_back(e16); t16.push_back(cyc); acc16++; end
            if (ov8 && !pv8 && t8.size() > 0) chk("lat8r", cyc - t8.pop_front(), 3);
            if (ov16 && !pv16 && t16.size() > 0) chk("lat16r", cyc - t16.pop_front(), 2);
            if (ov8 && ir8) begin
                chk("q8", 32'(q8.size() > 0), 1);
                if (q8.size() > 0) chk("sum8r", 32'(sum8), 32'(q8.pop_front()));
                res8++;
            end
            if (ov16 && ir16) begin
                chk("q16", 32'(q16.size() > 0), 1);
                if (q16.size() > 0) chk("sum16r", 32'(sum16), 32'(q16.pop_front()));
                res16++;
            end
            pv8 = ov8;
            pv16 = ov16;
        end
    end

    initial begin
        rst = 1'b1;
        v8 = 0; s8 = 0; c8 = 0; ir8 = 0; e8 = 0;
        v16 = 0; s16 = 0; c16 = 0; ir16 = 0; e16 = 0;
        step(); step();
        chk("rst_ov8", 32'(ov8), 0);
        chk("rst_sum8", 32'(sum8), 0);
        chk("rst_rdy8", 32'(r8), 1);
        chk("rst_ov16", 32'(ov16), 0);
        chk("rst_rdy16", 32'(r16), 1);
        rst = 1'b0;
        step();

        run8(8'hFF, 9'h1FE, 0);
        run8(8'h00, 9'h000, 0);
        run8(8'h0F, 9'h002, 0);
        run8(8'h00, 9'h001, 0);
        run8(8'h12, 9'h034, 5);

        v8 = 1'b1; s8 = 8'h77; c8 = 9'h0AA;
        step();
        v8 = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ov", 32'(ov8), 0);
        chk("mid_rst_sum", 32'(sum8), 0);
        chk("mid_rst_rdy", 32'(r8), 1);
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("discard", 32'(ov8), 0);
        run8(8'h80, 9'h100, 0);

        mon = 1'b1;
        fork
            begin
                int k = 0;
                logic [7:0] a, b, c;
                while (acc8 < 1000 && k < 30000) begin
                    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) begin
                        s8 = 8'($urandom); c8 = 9'($urandom);
                        e8 = 10'(s8) + 10'(c8);
                    end else begin
                        s8 = a ^ b ^ c;
                        c8 = {(a & b) | (a & c) | (b & c), 1'b0};
                        e8 = 10'(a) + 10'(b) + 10'(c);
                    end
                    v8 = 1'($urandom_range(0, 1));
                    ir8 = ($urandom_range(0, 3) != 0);
                    step();
                    k++;
                end
                v8 = 1'b0; ir8 = 1'b1;
                k = 0;
                while (q8.size() > 0 && k < 50) begin step(); k++; end
            end
            begin
                int k = 0;
                logic [15:0] a, b, c;
                while (acc16 < 1000 && k < 30000) begin
                    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
                    if ($urandom_range(0, 3) == 0) begin
                        s16 = 16'($urandom); c16 = 17'($urandom);
                        e16 = 18'(s16) + 18'(c16);
                    end else begin
                        s16 = a ^ b ^ c;
                        c16 = {(a & b) | (a & c) | (b & c), 1'b0};
                        e16 = 18'(a) + 18'(b) + 18'(c);
                    end
                    v16 = 1'($urandom_range(0, 1));
                    ir16 = ($urandom_range(0, 3) != 0);
                    step();
                    k++;
                end
                v16 = 1'b0; ir16 = 1'b1;
                k = 0;
                while (q16.size() > 0 && k < 50) begin step(); k++; end
            end
        join
        step();
        mon = 1'b0;
        chk("acc8", acc8, 1000);
        chk("cnt8", res8, 1000);
        chk("drain8", q8.size(), 0);
        chk("acc16", acc16, 1000);
        chk("cnt16", res16, 1000);
        chk("drain16", q16.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
